mem_wb_skid_reg: RTL and testbench

Parametrised successor to the MEM/WB stage register. It carries writeback control and data from MEM to WB through a valid/ready handshake and a 2-entry skid buffer, so upstream ready is fully registered. It also supports pipeline flush, bubble gating, x0-write suppression, a muxed writeback value for forwarding, and a saturating backpressure counter. It sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_skid_reg_pkg.sv | 37 +++
 rtl/mem_wb_skid_reg_skid_buffer.sv | 104 ++++++++++
 rtl/mem_wb_skid_reg.sv | 98 +++++++++
 tb/tb_mem_wb_skid_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg_pkg
// Shared definitions for the MEM/WB stage register family.
//   wb_entry_t          : writeback entry {reg_write, mem_to_reg, rd, mem_out,
//                         write_data} at the default widths, reused by other
//                         stage registers.
//   wb_payload_width()  : flattened entry width for arbitrary widths.
//   suppress_reg_write(): x0-write suppression applied at capture.
// -----------------------------------------------------------------------------
package mem_wb_skid_reg_pkg;

    localparam int WB_BUS_WIDTH   = 64;
    localparam int WB_REGFILE_LEN = 6;

    typedef struct packed {
        logic                      reg_write;
        logic                      mem_to_reg;
        logic [WB_REGFILE_LEN-1:0] rd;
        logic [WB_BUS_WIDTH-1:0]   mem_out;
        logic [WB_BUS_WIDTH-1:0]   write_data;
    } wb_entry_t;

    localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);

    // Flattened entry width: two control bits, rd, and the two data words.
    function automatic int wb_payload_width(input int bus_width, input int regfile_len);
        return 2 + regfile_len + (2 * bus_width);
    endfunction

    // A write to the hard-wired zero register is turned into a no-op.
    function automatic logic suppress_reg_write(input logic reg_write,
                                                input logic rd_is_zero,
                                                input logic enable);
        return reg_write & ~(enable & rd_is_zero);
    endfunction

endpackage

// File: rtl/mem_wb_skid_reg_skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Generic 2-slot valid/ready buffer over a flattened payload. The upstream
// ready is a flop (the registered complement of the next skid valid), so there
// is no combinational path from out_ready to in_ready. FIFO order is always
// preserved: the skid slot only ever drains into the main slot.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : drop both slots, reopen the input
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data = main slot payload
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r;
    logic         skid_valid_r;
    logic         in_ready_r;
    logic [W-1:0] main_data_r;
    logic [W-1:0] skid_data_r;

    logic         main_valid_s;
    logic         skid_valid_s;
    logic [W-1:0] main_data_s;
    logic [W-1:0] skid_data_s;
    logic         accept_s;
    logic         consume_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = main_valid_r & out_ready;

    // Next-state selection for both slots.
    always_comb begin
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_data_s  = main_data_r;
        skid_data_s  = skid_data_r;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (skid_valid_r) begin
            // in_ready is low while skid is full, so no accept here.
            if (consume_s) begin
                main_data_s  = skid_data_r;
                main_valid_s = 1'b1;
                skid_valid_s = 1'b0;
            end else begin
                main_valid_s = main_valid_r;
            end
        end else if (main_valid_r) begin
            if (consume_s) begin
                if (accept_s) begin
                    main_data_s  = in_data;
                    main_valid_s = 1'b1;
                end else begin
                    main_valid_s = 1'b0;
                end
            end else if (accept_s) begin
                skid_data_s  = in_data;
                skid_valid_s = 1'b1;
            end else begin
                skid_valid_s = 1'b0;
            end
        end else if (accept_s) begin
            main_data_s  = in_data;
            main_valid_s = 1'b1;
        end else begin
            main_valid_s = 1'b0;
        end
    end

    // Slot state, payload and registered upstream ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_data_r  <= {W{1'b0}};
            skid_data_r  <= {W{1'b0}};
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg
// MEM/WB stage register with valid/ready handshake and a 2-entry skid buffer.
// Adds x0-write suppression on capture, bubble gating of reg_write, the
// writeback value mux used for forwarding, and a saturating stall counter.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   flush                    : discard held entries
//   in_valid/in_ready, in_*  : entry from MEM
//   out_valid/out_ready, out_*: head entry toward WB
//   out_wb_data              : out_mem_to_reg ? out_mem_out : out_write_data
//   stall_count              : saturating count of out_valid & ~out_ready edges
// -----------------------------------------------------------------------------
module mem_wb_skid_reg
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int BUS_WIDTH         = 64,
    parameter int REGFILE_LEN       = 6,
    parameter bit ZERO_REG_SUPPRESS = 1'b1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_reg_write,
    input  logic                   in_mem_to_reg,
    input  logic [REGFILE_LEN-1:0] in_rd,
    input  logic [BUS_WIDTH-1:0]   in_mem_out,
    input  logic [BUS_WIDTH-1:0]   in_write_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_reg_write,
    output logic                   out_mem_to_reg,
    output logic [REGFILE_LEN-1:0] out_rd,
    output logic [BUS_WIDTH-1:0]   out_mem_out,
    output logic [BUS_WIDTH-1:0]   out_write_data,
    output logic [BUS_WIDTH-1:0]   out_wb_data,
    output logic [CNT_WIDTH-1:0]   stall_count
);

    localparam int PW = wb_payload_width(BUS_WIDTH, REGFILE_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                   cap_reg_write_s;
    logic [PW-1:0]          in_payload_s;
    logic [PW-1:0]          out_payload_s;
    logic                   head_valid_s;
    logic                   head_reg_write_s;
    logic [CNT_WIDTH-1:0]   stall_count_r;

    assign cap_reg_write_s = suppress_reg_write(in_reg_write,
                                                (in_rd == {REGFILE_LEN{1'b0}}),
                                                ZERO_REG_SUPPRESS);

    assign in_payload_s = {cap_reg_write_s, in_mem_to_reg, in_rd, in_mem_out, in_write_data};

    skid_buffer #(
        .W (PW)
    ) u_skid_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload_s),
        .out_valid (head_valid_s),
        .out_ready (out_ready),
        .out_data  (out_payload_s)
    );

    assign head_reg_write_s = out_payload_s[PW-1];
    assign out_mem_to_reg   = out_payload_s[PW-2];
    assign out_rd           = out_payload_s[PW-3 -: REGFILE_LEN];
    assign out_mem_out      = out_payload_s[2*BUS_WIDTH-1 -: BUS_WIDTH];
    assign out_write_data   = out_payload_s[BUS_WIDTH-1:0];

    // Stale payload stays in the head slot after drain/flush; gating keeps it
    // from reaching the register file.
    assign out_valid     = head_valid_s;
    assign out_reg_write = head_reg_write_s & head_valid_s;
    assign out_wb_data   = out_mem_to_reg ? out_mem_out : out_write_data;

    // Saturating stall counter; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= {CNT_WIDTH{1'b0}};
        end else if (head_valid_s && !out_ready && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_WIDTH'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
module tb_mem_wb_skid_reg;

    localparam int BW = 64;
    localparam int RL = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_reg_write;
    logic          in_mem_to_reg;
    logic [RL-1:0] in_rd;
    logic [BW-1:0] in_mem_out;
    logic [BW-1:0] in_write_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_reg_write;
    logic          out_mem_to_reg;
    logic [RL-1:0] out_rd;
    logic [BW-1:0] out_mem_out;
    logic [BW-1:0] out_write_data;
    logic [BW-1:0] out_wb_data;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rw;
        logic          m2r;
        logic [RL-1:0] rd;
        logic [BW-1:0] wb;
    } exp_t;

    exp_t q[$];

    mem_wb_skid_reg #(
        .BUS_WIDTH         (BW),
        .REGFILE_LEN       (RL),
        .ZERO_REG_SUPPRESS (1'b1),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_rd          (in_rd),
        .in_mem_out     (in_mem_out),
        .in_write_data  (in_write_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_reg_write  (out_reg_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_rd         (out_rd),
        .out_mem_out    (out_mem_out),
        .out_write_data (out_write_data),
        .out_wb_data    (out_wb_data),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one entry; push its expected writeback when it will be accepted.
    task automatic send(input logic rw, input logic m2r, input logic [RL-1:0] rd,
                        input logic [BW-1:0] mo, input logic [BW-1:0] wd, input bit will_accept);
        exp_t e;
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_rd         = rd;
        in_mem_out    = mo;
        in_write_data = wd;
        if (will_accept) begin
            e.rw  = rw & (rd != '0);
            e.m2r = m2r;
            e.rd  = rd;
            e.wb  = m2r ? mo : wd;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Scoreboard: every consume edge pops the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_output", {{(BW-RL){1'b0}}, out_rd}, {BW{1'b1}});
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_rd", {{(BW-RL){1'b0}}, out_rd}, {{(BW-RL){1'b0}}, e.rd});
                check("sb_reg_write", {{(BW-1){1'b0}}, out_reg_write}, {{(BW-1){1'b0}}, e.rw});
                check("sb_mem_to_reg", {{(BW-1){1'b0}}, out_mem_to_reg}, {{(BW-1){1'b0}}, e.m2r});
                check("sb_wb_data", out_wb_data, e.wb);
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_rd = '0; in_mem_out = '0; in_write_data = '0;

        // Reset held with in_valid=1
        send(1'b1, 1'b0, 6'd4, 64'h1111, 64'h44, 1'b0);
        step(); step(); step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_stall", {60'd0, stall_count}, 64'd0);
        check("rst_reg_write", {63'd0, out_reg_write}, 64'd0);
        check("rst_rd", {58'd0, out_rd}, 64'd0);
        check("rst_wb_data", out_wb_data, 64'd0);

        // First entry after reset, 1-cycle latency
        send(1'b1, 1'b0, 6'd4, 64'h1111, 64'h44, 1'b1);
        rst = 1'b1;
        step();
        idle();
        check("first_valid", {63'd0, out_valid}, 64'd1);
        check("first_rd", {58'd0, out_rd}, 64'd4);
        out_ready = 1'b1;
        step();
        check("first_drained", {63'd0, out_valid}, 64'd0);

        // Streaming at full rate
        send(1'b1, 1'b0, 6'd5, 64'h2222, 64'hA, 1'b1);
        step();
        check("stream_rd0", {58'd0, out_rd}, 64'd5);
        check("stream_rdy0", {63'd0, in_ready}, 64'd1);
        send(1'b1, 1'b0, 6'd7, 64'h3333, 64'hB, 1'b1);
        step();
        check("stream_rd1", {58'd0, out_rd}, 64'd7);
        check("stream_rdy1", {63'd0, in_ready}, 64'd1);
        send(1'b1, 1'b0, 6'd9, 64'h4444, 64'hC, 1'b1);
        step();
        idle();
        check("stream_rd2", {58'd0, out_rd}, 64'd9);
        check("stream_vld2", {63'd0, out_valid}, 64'd1);
        check("stream_rdy2", {63'd0, in_ready}, 64'd1);
        step();
        check("stream_empty", {63'd0, out_valid}, 64'd0);
        check("bubble_gate", {63'd0, out_reg_write}, 64'd0);

        // Backpressure
        out_ready = 1'b0;
        send(1'b1, 1'b0, 6'd1, 64'h0, 64'h101, 1'b1);
        step();
        check("bp_rdy_after_1", {63'd0, in_ready}, 64'd1);
        send(1'b1, 1'b0, 6'd2, 64'h0, 64'h102, 1'b1);
        step();
        check("bp_rdy_after_2", {63'd0, in_ready}, 64'd0);
        send(1'b1, 1'b0, 6'd3, 64'h0, 64'h103, 1'b0);
        step(); step(); step();
        check("bp_rdy_held", {63'd0, in_ready}, 64'd0);
        check("bp_head", {58'd0, out_rd}, 64'd1);
        check("bp_stall4", {60'd0, stall_count}, 64'd4);
        out_ready = 1'b1;
        step();
        check("bp_rdy_reopen", {63'd0, in_ready}, 64'd1);
        check("bp_head2", {58'd0, out_rd}, 64'd2);
        send(1'b1, 1'b0, 6'd3, 64'h0, 64'h103, 1'b1);
        step();
        idle();
        check("bp_head3", {58'd0, out_rd}, 64'd3);
        step();
        check("bp_drained", {63'd0, out_valid}, 64'd0);
        check("bp_stall_kept", {60'd0, stall_count}, 64'd4);

        // Flush with both slots full and a new entry offered
        out_ready = 1'b0;
        send(1'b1, 1'b0, 6'd10, 64'h0, 64'h10, 1'b0);
        step();
        send(1'b1, 1'b0, 6'd11, 64'h0, 64'h11, 1'b0);
        step();
        check("fl_full", {63'd0, in_ready}, 64'd0);
        send(1'b1, 1'b0, 6'd8, 64'h0, 64'h8, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_ready", {63'd0, in_ready}, 64'd1);
        check("fl_reg_write", {63'd0, out_reg_write}, 64'd0);
        check("fl_stall", {60'd0, stall_count}, 64'd6);
        out_ready = 1'b1;
        step();
        check("fl_rd8_dropped", {63'd0, out_valid}, 64'd0);

        // Writeback mux and x0 suppression
        out_ready = 1'b0;
        send(1'b1, 1'b1, 6'd3, 64'hDEAD, 64'hBEEF, 1'b1);
        step();
        check("mux_wb", out_wb_data, 64'hDEAD);
        check("mux_rw", {63'd0, out_reg_write}, 64'd1);
        out_ready = 1'b1;
        send(1'b1, 1'b1, 6'd0, 64'hDEAD, 64'hBEEF, 1'b1);
        step();
        idle();
        check("x0_rd", {58'd0, out_rd}, 64'd0);
        check("x0_rw", {63'd0, out_reg_write}, 64'd0);
        check("x0_wb", out_wb_data, 64'hDEAD);
        step();

        // Saturation of the 4-bit stall counter
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("sat_reset", {60'd0, stall_count}, 64'd0);
        out_ready = 1'b0;
        send(1'b1, 1'b0, 6'd12, 64'h0, 64'h12, 1'b1);
        step();
        idle();
        for (int i = 0; i < 20; i++) step();
        check("sat_count", {60'd0, stall_count}, 64'd15);
        check("sat_head", {58'd0, out_rd}, 64'd12);
        out_ready = 1'b1;
        step();
        check("sat_drained", {63'd0, out_valid}, 64'd0);
        check("sb_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
